// File: rtl/systolic_array_v2.sv
// Weight-stationary systolic MAC array: double-buffered weights, skewed per-tap
// activation pipeline, multi-tile accumulation groups and rounding requantisation.
module systolic_array_v2 #(
   parameter int unsigned ROWS    = 4,
   parameter int unsigned TAPS    = 2,
   parameter int unsigned BW_ACT  = 8,
   parameter int unsigned BW_WET  = 8,
   parameter int unsigned BW_ACCU = 32,
   parameter int unsigned BW_OUT  = 8,
   parameter int unsigned SHW     = $clog2(BW_ACCU)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wet_valid,
   output logic                   wet_ready,
   input  logic [BW_WET-1:0]      wet_in,
   input  logic                   act_valid,
   output logic                   act_ready,
   input  logic [TAPS*BW_ACT-1:0] act_in,
   input  logic                   act_last,
   input  logic [SHW-1:0]         res_shift,
   input  logic                   round_en,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ROWS*BW_OUT-1:0] out_data,
   output logic                   busy
);

   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CW = $clog2(TAPS + 2);
   localparam logic [TAPS-1:0] LOW_MASK = TAPS'((64'd1 << (TAPS - 1)) - 64'd1);
   localparam logic signed [BW_ACCU:0] SAT_HI = (BW_ACCU+1)'((64'sd1 <<< (BW_OUT - 1)) - 64'sd1);
   localparam logic signed [BW_ACCU:0] SAT_LO = (BW_ACCU+1)'(-(64'sd1 <<< (BW_OUT - 1)));

   typedef enum logic [1:0] {LOAD_W, STREAM, DRAIN, OUT} state_t;

   state_t                   state;
   logic [CW-1:0]            tap_cnt;
   logic [RW-1:0]            row_cnt;
   logic [TAPS*BW_WET-1:0]   w_sh, w_act, w_sh_nxt;
   logic [TAPS*BW_ACT-1:0]   p_act [TAPS];
   logic [TAPS*BW_WET-1:0]   p_wet [TAPS];
   logic signed [BW_ACCU-1:0] p_sum [TAPS];
   logic [RW-1:0]            p_row [TAPS];
   logic [TAPS-1:0]          p_vld;
   logic signed [BW_ACCU-1:0] acc [ROWS];
   logic [SHW-1:0]           shift_q;
   logic                     round_q;
   logic                     act_fire, wet_fire, pipe_next_c;
   logic signed [BW_ACCU-1:0] last_sum_c;

   function automatic logic signed [BW_ACCU-1:0] mac_term(input logic [BW_ACT-1:0] a,
                                                          input logic [BW_WET-1:0] w);
      logic signed [BW_ACT+BW_WET-1:0] p;
      p = $signed(a) * $signed(w);
      return BW_ACCU'(p);
   endfunction

   function automatic logic [BW_OUT-1:0] requant(input logic signed [BW_ACCU-1:0] a,
                                                 input logic [SHW-1:0] s,
                                                 input logic rnd);
      logic signed [BW_ACCU:0] t;
      t = (BW_ACCU+1)'(a);
      if (rnd && s != '0)
         t = t + $signed((BW_ACCU+1)'(1) << (s - SHW'(1)));
      t = t >>> s;
      if (t > SAT_HI) return BW_OUT'(SAT_HI);
      if (t < SAT_LO) return BW_OUT'(SAT_LO);
      return BW_OUT'(t);
   endfunction

   assign act_fire    = act_valid & act_ready;
   assign wet_fire    = wet_valid & wet_ready;
   assign pipe_next_c = act_fire | (|(p_vld & LOW_MASK));
   assign last_sum_c  = p_sum[TAPS-1] + mac_term(p_act[TAPS-1][(TAPS-1)*BW_ACT +: BW_ACT],
                                                 p_wet[TAPS-1][(TAPS-1)*BW_WET +: BW_WET]);

   // Shadow chain after one more beat: new beat enters tap 0, others move up.
   always_comb begin
      w_sh_nxt = w_sh;
      w_sh_nxt[0 +: BW_WET] = wet_in;
      for (int k = 1; k < int'(TAPS); k++)
         w_sh_nxt[k*BW_WET +: BW_WET] = w_sh[(k-1)*BW_WET +: BW_WET];
   end

   // Skew pipeline: stage k has taps 0..k-1 summed; each beat carries its own weights.
   always_ff @(posedge clk) begin
      if (reset) begin
         p_vld <= '0;
         for (int k = 0; k < int'(TAPS); k++) begin
            p_act[k] <= '0;
            p_wet[k] <= '0;
            p_sum[k] <= '0;
            p_row[k] <= '0;
         end
      end else begin
         p_vld[0] <= act_fire;
         p_act[0] <= act_in;
         p_wet[0] <= w_act;
         p_row[0] <= row_cnt;
         p_sum[0] <= '0;
         for (int k = 1; k < int'(TAPS); k++) begin
            p_vld[k] <= p_vld[k-1];
            p_act[k] <= p_act[k-1];
            p_wet[k] <= p_wet[k-1];
            p_row[k] <= p_row[k-1];
            p_sum[k] <= p_sum[k-1] + mac_term(p_act[k-1][(k-1)*BW_ACT +: BW_ACT],
                                              p_wet[k-1][(k-1)*BW_WET +: BW_WET]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= LOAD_W;
         tap_cnt   <= '0;
         row_cnt   <= '0;
         w_sh      <= '0;
         w_act     <= '0;
         shift_q   <= '0;
         round_q   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         act_ready <= 1'b0;
         wet_ready <= 1'b1;
         busy      <= 1'b0;
         for (int r = 0; r < int'(ROWS); r++) acc[r] <= '0;
      end else begin
         if (p_vld[TAPS-1])
            acc[p_row[TAPS-1]] <= acc[p_row[TAPS-1]] + last_sum_c;
         case (state)
            LOAD_W: begin
               if (wet_fire) begin
                  w_sh <= w_sh_nxt;
                  busy <= 1'b1;
                  if (tap_cnt == CW'(TAPS - 1)) begin
                     w_act     <= w_sh_nxt;
                     tap_cnt   <= '0;
                     wet_ready <= 1'b0;
                     act_ready <= 1'b1;
                     state     <= STREAM;
                  end else begin
                     tap_cnt <= tap_cnt + CW'(1);
                  end
               end else begin
                  busy <= (tap_cnt != '0) | pipe_next_c;
               end
            end
            STREAM: begin
               if (act_fire) begin
                  if (row_cnt == RW'(ROWS - 1)) begin
                     row_cnt   <= '0;
                     act_ready <= 1'b0;
                     if (act_last) begin
                        shift_q <= res_shift;
                        round_q <= round_en;
                        tap_cnt <= '0;
                        state   <= DRAIN;
                     end else begin
                        wet_ready <= 1'b1;
                        state     <= LOAD_W;
                     end
                  end else begin
                     row_cnt <= row_cnt + RW'(1);
                  end
               end
            end
            // Last beat lands in acc TAPS edges after acceptance; publish two edges later.
            DRAIN: begin
               if (tap_cnt == CW'(TAPS + 1)) begin
                  tap_cnt   <= '0;
                  out_valid <= 1'b1;
                  state     <= OUT;
                  for (int r = 0; r < int'(ROWS); r++)
                     out_data[r*BW_OUT +: BW_OUT] <= requant(acc[r], shift_q, round_q);
               end else begin
                  tap_cnt <= tap_cnt + CW'(1);
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  wet_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= LOAD_W;
                  for (int r = 0; r < int'(ROWS); r++) acc[r] <= '0;
               end
            end
            default: state <= LOAD_W;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_array_v2.sv
// Scoreboard bench for systolic_array_v2: model results queued at stimulus time,
// popped and compared when the array presents a result vector.
module tb_systolic_array_v2;
   localparam int unsigned ROWS = 4, TAPS = 2, BW_ACT = 8, BW_WET = 8;
   localparam int unsigned BW_ACCU = 32, BW_OUT = 8, SHW = 5;
   localparam int LIM = 200;

   logic                   clk, reset;
   logic                   wet_valid, wet_ready;
   logic [BW_WET-1:0]      wet_in;
   logic                   act_valid, act_ready, act_last;
   logic [TAPS*BW_ACT-1:0] act_in;
   logic [SHW-1:0]         res_shift;
   logic                   round_en, out_valid, out_ready, busy;
   logic [ROWS*BW_OUT-1:0] out_data;

   systolic_array_v2 #(.ROWS(ROWS), .TAPS(TAPS), .BW_ACT(BW_ACT), .BW_WET(BW_WET),
                       .BW_ACCU(BW_ACCU), .BW_OUT(BW_OUT), .SHW(SHW)) dut (
      .clk(clk), .reset(reset),
      .wet_valid(wet_valid), .wet_ready(wet_ready), .wet_in(wet_in),
      .act_valid(act_valid), .act_ready(act_ready), .act_in(act_in), .act_last(act_last),
      .res_shift(res_shift), .round_en(round_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, failures = 0;
   int m_w[TAPS];
   int m_acc[ROWS];
   int rows_a[ROWS][TAPS];
   logic [ROWS*BW_OUT-1:0] exp_q[$];
   int final_cyc = 0;
   bit illegal = 0, junk_last = 0;
   int cur_shift = 0;
   bit cur_rnd = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rq(input int a, input int s, input bit rnd);
      longint t;
      t = longint'(a);
      if (rnd && s > 0) t = t + (longint'(1) << (s - 1));
      t = t >>> s;
      if (t > 127) return 127;
      if (t < -128) return -128;
      return int'(t);
   endfunction

   function automatic logic [ROWS*BW_OUT-1:0] model_out(input int s, input bit rnd);
      logic [ROWS*BW_OUT-1:0] v;
      for (int r = 0; r < int'(ROWS); r++) v[r*BW_OUT +: BW_OUT] = 8'(rq(m_acc[r], s, rnd));
      return v;
   endfunction

   task automatic send_wet(input int val);
      int guard = 0;
      @(negedge clk);
      wet_valid = 1'b1;
      wet_in    = 8'(val);
      if (illegal) begin act_valid = 1'b1; act_in = 16'hA5A5; end
      while (!wet_ready && guard < LIM) begin @(negedge clk); guard++; end
      if (guard >= LIM) check("wet_ready_wait", 64'(wet_ready), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic send_act(input int a0, input int a1, input bit last);
      int guard = 0;
      @(negedge clk);
      act_valid = 1'b1;
      act_in    = {8'(a1), 8'(a0)};
      act_last  = last;
      res_shift = SHW'(cur_shift);
      round_en  = cur_rnd;
      if (illegal) begin wet_valid = 1'b1; wet_in = 8'd99; end
      while (!act_ready && guard < LIM) begin @(negedge clk); guard++; end
      if (guard >= LIM) check("act_ready_wait", 64'(act_ready), 64'd1);
      @(posedge clk); #1;
   endtask

   // Weights sent tap 1 first, tap 0 last.
   task automatic load_w(input int w0, input int w1);
      m_w[0] = w0;
      m_w[1] = w1;
      send_wet(w1);
      send_wet(w0);
      @(negedge clk);
      wet_valid = 1'b0;
      act_valid = 1'b0;
   endtask

   task automatic stream(input bit last);
      for (int r = 0; r < int'(ROWS); r++) begin
         send_act(rows_a[r][0], rows_a[r][1], (r == int'(ROWS) - 1) ? last : junk_last);
         m_acc[r] += rows_a[r][0] * m_w[0] + rows_a[r][1] * m_w[1];
      end
      final_cyc = cyc;
      @(negedge clk);
      act_valid = 1'b0;
      wet_valid = 1'b0;
      act_last  = 1'b0;
      if (last) begin
         exp_q.push_back(model_out(cur_shift, cur_rnd));
         for (int r = 0; r < int'(ROWS); r++) m_acc[r] = 0;
      end
   endtask

   task automatic collect(input int hold);
      int guard = 0;
      logic [ROWS*BW_OUT-1:0] e;
      while (!out_valid && guard < LIM) begin @(posedge clk); #1; guard++; end
      check("latency", 64'(cyc - final_cyc), 64'(TAPS + 2));
      check("busy_out", 64'(busy), 64'd1);
      if (exp_q.size() == 0) begin
         check("queue_empty", 64'(exp_q.size()), 64'd1);
      end else begin
         e = exp_q.pop_front();
         check("out_data", 64'(out_data), 64'(e));
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_data", 64'(out_data), 64'(e));
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_act_ready", 64'(act_ready), 64'd0);
            check("hold_wet_ready", 64'(wet_ready), 64'd0);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("post_valid", 64'(out_valid), 64'd0);
      check("post_wet_ready", 64'(wet_ready), 64'd1);
   endtask

   task automatic set_rows(input int a00, a01, a10, a11, a20, a21, a30, a31);
      rows_a[0][0] = a00; rows_a[0][1] = a01;
      rows_a[1][0] = a10; rows_a[1][1] = a11;
      rows_a[2][0] = a20; rows_a[2][1] = a21;
      rows_a[3][0] = a30; rows_a[3][1] = a31;
   endtask

   task automatic group1(input int hold);
      load_w(2, 3);
      set_rows(1, 1, 2, 0, 0, 2, -1, -1);
      stream(1'b1);
      collect(hold);
   endtask

   initial begin
      reset = 1'b1; wet_valid = 0; wet_in = '0; act_valid = 0; act_in = '0; act_last = 0;
      res_shift = '0; round_en = 0; out_ready = 0;
      for (int r = 0; r < int'(ROWS); r++) m_acc[r] = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_act_ready", 64'(act_ready), 64'd0);
      check("rst_wet_ready", 64'(wet_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;

      group1(0);
      cur_rnd = 1;                       // shift 0 with rounding adds nothing
      group1(0);
      cur_rnd = 0;

      junk_last = 1;                     // act_last on rows 0..2 must be ignored
      load_w(2, 3);
      set_rows(1, 1, 2, 0, 0, 2, -1, -1);
      stream(1'b0);
      load_w(2, 3);
      stream(1'b1);
      collect(0);
      junk_last = 0;

      cur_shift = 7;
      load_w(127, 127);
      set_rows(127, 127, -128, -128, 1, 0, 0, 0);
      stream(1'b1);
      collect(0);
      cur_shift = 1;
      for (int rr = 0; rr < 2; rr++) begin
         cur_rnd = bit'(rr);
         load_w(1, 0);
         set_rows(5, 0, -5, 0, 3, 0, 0, 0);
         stream(1'b1);
         collect(0);
      end
      cur_shift = 0; cur_rnd = 0;

      group1(5);
      group1(0);

      load_w(2, 3);
      send_act(1, 1, 1'b0);
      send_act(2, 0, 1'b0);
      @(negedge clk);
      act_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_wet_ready", 64'(wet_ready), 64'd1);
      check("midrst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      group1(0);

      illegal = 1;
      group1(0);
      illegal = 0;

      for (int g = 0; g < 6; g++) begin
         int tiles;
         tiles = int'($urandom_range(1, 3));
         cur_shift = int'($urandom_range(0, 12));
         cur_rnd = bit'($urandom_range(0, 1));
         junk_last = bit'($urandom_range(0, 1));
         for (int t = 0; t < tiles; t++) begin
            load_w(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            for (int r = 0; r < int'(ROWS); r++)
               for (int k = 0; k < int'(TAPS); k++)
                  rows_a[r][k] = int'($urandom_range(0, 255)) - 128;
            stream(t == tiles - 1);
         end
         collect(int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/systolic_array_v2.md
Name: systolic_array_v2

Overview:
- Weight-stationary systolic MAC array. Successor of the v1 array; parametrised in rows, taps and output width.
- Adds valid/ready handshakes, internal activation skewing, double-buffered weights, multi-tile accumulation groups, and optional round-to-nearest before saturation.
- Sits between the activation/weight buffers and the output-activation writeback. Each group yields ROWS requantised results.

Parameters:
- ROWS, 4, rows per group (PE rows, one result each)
- TAPS, 2, accumulate taps per row per tile
- BW_ACT, 8, signed activation width
- BW_WET, 8, signed weight width
- BW_ACCU, 32, signed accumulator width
- BW_OUT, 8, signed result width
- SHW, $clog2(BW_ACCU), shift-amount width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wet_valid  in  1  weight beat valid
- wet_ready  out  1  weight beat accepted when valid&ready
- wet_in  in  BW_WET  weight beat
- act_valid  in  1  activation beat valid
- act_ready  out  1  activation beat accepted when valid&ready
- act_in  in  TAPS*BW_ACT  one activation row; lane k = bits [k*BW_ACT +: BW_ACT]
- act_last  in  1  marks final tile of group; qualified on row ROWS-1 only
- res_shift  in  SHW  arithmetic right shift for requantisation
- round_en  in  1  add 2^(res_shift-1) before shift when res_shift>0
- out_valid  out  1  result vector valid
- out_ready  in  1  result accepted when valid&ready
- out_data  out  ROWS*BW_OUT  row r = bits [r*BW_OUT +: BW_OUT]
- busy  out  1  high in any state except LOAD_W with row/tap counters at 0 and pipeline empty

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset:
  - State goes to LOAD_W; all counters 0.
  - Shadow and active weights and all accumulators cleared to 0; pipeline flushed.
  - Outputs: out_valid=0, out_data=0, act_ready=0, wet_ready=1, busy=0.
  - Reset mid-operation discards everything in flight.
- FSM state LOAD_W:
  - wet_ready=1, act_ready=0.
  - Each accepted beat shifts the shadow chain: sh[0]<=wet_in, sh[k]<=sh[k-1]. Feed tap TAPS-1 first, tap 0 last.
  - After TAPS beats: active<=shadow in the same edge, then go to STREAM.
- FSM state STREAM:
  - act_ready=1, wet_ready=0.
  - Beat r (0..ROWS-1) is row r. Row r partial = sum_k act_in[k]*w_active[k], added to acc[r].
  - Skewing is internal. Each beat uses the active weights in force when it was accepted, even if a later reload overlaps it in the pipeline.
  - After beat ROWS-1: if act_last=1, go to DRAIN; else go to LOAD_W for the next tile. Accumulators are kept.
- FSM state DRAIN:
  - Both readies 0.
  - res_shift and round_en are sampled at the final beat.
  - out_valid rises exactly TAPS+2 cycles after the edge accepting the final beat. Then go to OUT.
- FSM state OUT:
  - out_valid=1; out_data held stable until out_ready=1.
  - On handshake: accumulators cleared, out_valid=0, go to LOAD_W.
  - act_ready and wet_ready stay 0 while out_valid=1.
- Arithmetic:
  - Product is BW_ACT+BW_WET signed, sign-extended to BW_ACCU.
  - Accumulation wraps modulo 2^BW_ACCU.
  - Requant: t = acc + (round_en && shift>0 ? 1<<(shift-1) : 0), computed in BW_ACCU+1 bits. Then t>>>shift. Then saturate to [-2^(BW_OUT-1), 2^(BW_OUT-1)-1].
- Boundaries:
  - Valid while ready=0 is ignored; no state change.
  - act_last on rows other than ROWS-1 is ignored.
  - Shift 0 with round_en=1 adds nothing.
  - No partial tiles: a group always ends on row ROWS-1.

Test Plan:
- Single tile, ROWS=4, TAPS=2. Weights w0=2, w1=3 (send 3, then 2). Rows [1,1], [2,0], [0,2], [-1,-1]; act_last on row 3; shift 0 -> out_data {5,4,6,-5}, out_valid exactly 4 cycles after the last beat.
- Two-tile group, same data both tiles, act_last only on tile 2 -> {10,8,12,-10}. The second weight load overlaps the drain of tile 1 without corruption.
- Requant, one row [127,127] with w=[127,127], shift 7 -> 127 (sat). Row [-128,-128] -> -128 (sat). acc=5, shift 1: round_en=0 -> 2, round_en=1 -> 3. acc=-5, shift 1 -> -3 and -2.
- Backpressure: hold out_ready=0 for 5 cycles -> out_data stable, act_ready=0 and wet_ready=0 throughout. After the handshake, the next group of test 1 returns {5,4,6,-5}, showing the clear.
- Reset mid-STREAM after 2 row beats -> next cycle out_valid=0, wet_ready=1, busy=0. A fresh group matches test 1 exactly.
- Illegal-phase beats: act_valid=1 during LOAD_W and wet_valid=1 with value 99 during STREAM -> no effect; results match test 1.
